// File: rtl/gesture_match_sched.sv
// Window capture and template replay sequencer for the similarity datapath.
// Streams WIN_LEN*NUM_TMPL vector/template beats, then returns the winning id.
module gesture_match_sched #(
  parameter int VEC_W    = 8,
  parameter int WIN_LEN  = 16,
  parameter int NUM_TMPL = 26,
  parameter int TIMEOUT  = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vec_valid,
  input  logic [VEC_W-1:0] i_vec_x,
  input  logic [VEC_W-1:0] i_vec_y,
  output logic             o_vec_ready,
  output logic [8:0]       o_lib_addr,
  input  logic [VEC_W-1:0] i_lib_x,
  input  logic [VEC_W-1:0] i_lib_y,
  output logic             o_sim_valid,
  output logic [8:0]       o_sim_index,
  output logic [VEC_W-1:0] o_sim_vec_x,
  output logic [VEC_W-1:0] o_sim_vec_y,
  output logic [VEC_W-1:0] o_sim_lib_x,
  output logic [VEC_W-1:0] o_sim_lib_y,
  input  logic             i_sim_done,
  input  logic [4:0]       i_sim_id,
  output logic             o_gest_valid,
  output logic [4:0]       o_gest_id,
  input  logic             i_gest_ready,
  output logic             o_err
);

  localparam int BEATS = WIN_LEN * NUM_TMPL;
  localparam int WA    = $clog2(WIN_LEN);
  localparam int FW    = WA + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state, state_d;

  logic [VEC_W-1:0] win_x [WIN_LEN];
  logic [VEC_W-1:0] win_y [WIN_LEN];

  logic [FW-1:0]    fill_cnt, fill_d;
  logic [8:0]       beat_cnt, beat_d;
  logic [TW-1:0]    tmo_cnt, tmo_d;

  logic             vr_d;
  logic             sv_d;
  logic [8:0]       si_d;
  logic [VEC_W-1:0] sx_d, sy_d;
  logic             gv_d;
  logic [4:0]       gid_d;
  logic             err_d;

  logic             accept;
  logic             drop;
  logic             last_fill;
  logic             last_beat;
  logic             tmo_hit;
  logic [WA-1:0]    widx;

  assign accept    = i_vec_valid && o_vec_ready;
  assign drop      = i_vec_valid &&
                     (state == S_ISSUE ||
                      state == S_WAIT  ||
                      state == S_HOLD);
  assign last_fill = fill_cnt == FW'(WIN_LEN - 1);
  assign last_beat = beat_cnt == 9'(BEATS - 1);
  assign tmo_hit   = tmo_cnt == TW'(TIMEOUT - 1);
  assign widx      = (state == S_FILL) ?
                     fill_cnt[WA-1:0] : '0;

  // ROM data arrives one cycle after the address, aligned with the beat
  assign o_sim_lib_x = o_sim_valid ? i_lib_x : '0;
  assign o_sim_lib_y = o_sim_valid ? i_lib_y : '0;
  assign o_lib_addr  = beat_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (accept) state_d = S_FILL;
      S_FILL:  if (accept && last_fill) state_d = S_ISSUE;
      S_ISSUE: if (last_beat) state_d = S_WAIT;
      S_WAIT:  if (i_sim_done || tmo_hit) state_d = S_HOLD;
      S_HOLD:  if (i_gest_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fill_d = '0;
    beat_d = '0;
    tmo_d  = '0;
    gv_d   = o_gest_valid;
    gid_d  = o_gest_id;
    err_d  = o_err | drop;
    sv_d   = state == S_ISSUE;
    si_d   = sv_d ? beat_cnt : '0;
    sx_d   = sv_d ? win_x[beat_cnt[WA-1:0]] : '0;
    sy_d   = sv_d ? win_y[beat_cnt[WA-1:0]] : '0;
    vr_d   = state_d == S_IDLE ||
             state_d == S_FILL;
    unique case (state)
      S_IDLE: begin
        if (accept) fill_d = FW'(1);
      end
      S_FILL: begin
        if (accept)
          fill_d = last_fill ? '0 : fill_cnt + FW'(1);
        else
          fill_d = fill_cnt;
      end
      S_ISSUE: begin
        beat_d = last_beat ? '0 : beat_cnt + 9'd1;
      end
      S_WAIT: begin
        if (i_sim_done) begin
          gv_d  = 1'b1;
          gid_d = i_sim_id;
        end else if (tmo_hit) begin
          gv_d  = 1'b1;
          gid_d = 5'h1F;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_cnt + TW'(1);
        end
      end
      S_HOLD: begin
        if (i_gest_ready) begin
          gv_d  = 1'b0;
          gid_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fill_cnt     <= '0;
      beat_cnt     <= '0;
      tmo_cnt      <= '0;
      o_vec_ready  <= 1'b0;
      o_sim_valid  <= 1'b0;
      o_sim_index  <= '0;
      o_sim_vec_x  <= '0;
      o_sim_vec_y  <= '0;
      o_gest_valid <= 1'b0;
      o_gest_id    <= '0;
      o_err        <= 1'b0;
    end else begin
      fill_cnt     <= fill_d;
      beat_cnt     <= beat_d;
      tmo_cnt      <= tmo_d;
      o_vec_ready  <= vr_d;
      o_sim_valid  <= sv_d;
      o_sim_index  <= si_d;
      o_sim_vec_x  <= sx_d;
      o_sim_vec_y  <= sy_d;
      o_gest_valid <= gv_d;
      o_gest_id    <= gid_d;
      o_err        <= err_d;
    end
  end

  // Window storage has no reset; a new window always refills from slot 0
  always_ff @(posedge i_clk) begin
    if (accept) begin
      win_x[widx] <= i_vec_x;
      win_y[widx] <= i_vec_y;
    end
  end

endmodule

// File: tb/tb_gesture_match_sched.sv
// Randomized bench for gesture_match_sched against a beat-list reference model.
// Expected beats come from window[b mod 16] and rom[b] for b = 0..415.
module tb_gesture_match_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       vec_valid;
  logic [7:0] vec_x, vec_y;
  logic       vec_ready;
  logic [8:0] lib_addr;
  logic [7:0] lib_x, lib_y;
  logic       sim_valid;
  logic [8:0] sim_index;
  logic [7:0] sim_vec_x, sim_vec_y;
  logic [7:0] sim_lib_x, sim_lib_y;
  logic       sim_done;
  logic [4:0] sim_id;
  logic       gest_valid;
  logic [4:0] gest_id;
  logic       gest_ready;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom_x [512];
  logic [7:0] rom_y [512];
  logic [7:0] mx [16];
  logic [7:0] my [16];

  always #5 clk = ~clk;

  gesture_match_sched dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_vec_valid  (vec_valid),
    .i_vec_x      (vec_x),
    .i_vec_y      (vec_y),
    .o_vec_ready  (vec_ready),
    .o_lib_addr   (lib_addr),
    .i_lib_x      (lib_x),
    .i_lib_y      (lib_y),
    .o_sim_valid  (sim_valid),
    .o_sim_index  (sim_index),
    .o_sim_vec_x  (sim_vec_x),
    .o_sim_vec_y  (sim_vec_y),
    .o_sim_lib_x  (sim_lib_x),
    .o_sim_lib_y  (sim_lib_y),
    .i_sim_done   (sim_done),
    .i_sim_id     (sim_id),
    .o_gest_valid (gest_valid),
    .o_gest_id    (gest_id),
    .i_gest_ready (gest_ready),
    .o_err        (err)
  );

  always_ff @(posedge clk) begin
    lib_x <= rom_x[lib_addr];
    lib_y <= rom_y[lib_addr];
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge clk);
    vec_valid = 1'b1;
    vec_x = x;
    vec_y = y;
    while (!vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_tmo", 0, 1);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic fill(input bit ramp);
    for (int k = 0; k < 16; k++) begin
      mx[k] = ramp ? 8'(k) : 8'($urandom);
      my[k] = ramp ? 8'(0 - k) : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(mx[k], my[k]);
    end
  endtask

  task automatic check_beats(input bit ramp, input bit inject);
    int  seen = 0;
    int  cyc  = 0;
    bit  gap  = 0;
    logic [40:0] exp;
    while (seen < 416 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (inject) vec_valid = (seen >= 100 && seen < 103);
      if (sim_valid) begin
        exp = {9'(seen), mx[seen % 16], my[seen % 16],
               rom_x[seen], rom_y[seen]};
        chk("beat", {sim_index, sim_vec_x, sim_vec_y,
                     sim_lib_x, sim_lib_y}, exp);
        if (ramp && seen == 37) begin
          chk("beat37_idx", sim_index, 37);
          chk("beat37_vec", {sim_vec_x, sim_vec_y}, {8'd5, 8'hFB});
          chk("beat37_lib", {sim_lib_x, sim_lib_y},
              {rom_x[37], rom_y[37]});
        end
        seen++;
      end else if (seen > 0) begin
        gap = 1'b1;
      end
    end
    vec_valid = 1'b0;
    chk("beat_count", seen, 416);
    chk("no_bubble", gap, 0);
  endtask

  task automatic finish_done(input int d, input logic [4:0] id);
    repeat (d) @(negedge clk);
    chk("wait_idle", {sim_valid, gest_valid}, 0);
    sim_done = 1'b1;
    sim_id = id;
    @(negedge clk);
    sim_done = 1'b0;
    chk("done_valid", gest_valid, 1);
    chk("done_id", gest_id, id);
  endtask

  task automatic wait_timeout();
    repeat (63) @(negedge clk);
    chk("tmo_early", gest_valid, 0);
    @(negedge clk);
    chk("tmo_valid", gest_valid, 1);
    chk("tmo_id", gest_id, 5'h1F);
    chk("tmo_err", err, 1);
  endtask

  task automatic hold_release(input int hold, input logic [4:0] id,
                              input bit inject);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", gest_valid, 1);
      chk("hold_id", gest_id, id);
      if (inject) vec_valid = (i == 0);
      @(negedge clk);
    end
    vec_valid = 1'b0;
    gest_ready = 1'b1;
    @(negedge clk);
    gest_ready = 1'b0;
    chk("rel_valid", gest_valid, 0);
    chk("rel_ready", vec_ready, 1);
  endtask

  initial begin
    logic [4:0] id;
    rst        = 1'b1;
    vec_valid  = 1'b0;
    vec_x      = '0;
    vec_y      = '0;
    sim_done   = 1'b0;
    sim_id     = '0;
    gest_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      rom_x[i] = 8'($urandom);
      rom_y[i] = 8'($urandom);
    end
    repeat (2) @(negedge clk);
    chk("rst_out", {vec_ready, lib_addr, sim_valid, sim_index,
                    sim_vec_x, sim_vec_y, sim_lib_x, sim_lib_y,
                    gest_valid, gest_id, err}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", vec_ready, 1);

    fill(1'b0);
    repeat (40) @(negedge clk);
    chk("mid_issue", sim_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_sim", {sim_valid, sim_lib_x, sim_vec_x}, 0);
    chk("arst_addr", lib_addr, 0);
    chk("arst_gest", gest_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {vec_ready, err}, 2'b10);

    sim_done = 1'b1;
    sim_id = 5'd7;
    @(negedge clk);
    sim_done = 1'b0;
    @(negedge clk);
    chk("idle_done", {gest_valid, err, vec_ready}, 3'b001);

    fill(1'b1);
    check_beats(1'b1, 1'b0);
    finish_done(3, 5'd12);
    hold_release(5, 5'd12, 1'b0);
    chk("a_err", err, 0);

    fill(1'b0);
    check_beats(1'b0, 1'b0);
    id = 5'($urandom_range(0, 30));
    finish_done(63, id);
    chk("edge_err", err, 0);
    hold_release($urandom_range(1, 4), id, 1'b0);

    fill(1'b0);
    check_beats(1'b0, 1'b1);
    chk("drop_issue_err", err, 1);
    id = 5'($urandom);
    finish_done($urandom_range(0, 62), id);
    hold_release(2, id, 1'b0);

    do_reset();
    chk("rst_clr_err", err, 0);
    fill(1'b0);
    check_beats(1'b0, 1'b0);
    wait_timeout();
    hold_release(2, 5'h1F, 1'b0);
    chk("tmo_sticky", err, 1);

    do_reset();
    fill(1'b0);
    check_beats(1'b0, 1'b0);
    id = 5'($urandom);
    finish_done($urandom_range(0, 62), id);
    chk("pre_hold_err", err, 0);
    hold_release(3, id, 1'b1);
    chk("drop_hold_err", err, 1);

    for (int r = 0; r < 2; r++) begin
      fill(1'b0);
      check_beats(1'b0, 1'b0);
      id = 5'($urandom);
      finish_done($urandom_range(0, 63), id);
      hold_release($urandom_range(1, 6), id, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
